// File: rtl/axi4_lite_pkg.sv
// Shared response codes, FSM state encodings and address-decode helper
// for the AXI4-Lite register slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_HAVE_A = 2'd1,
    WR_HAVE_D = 2'd2,
    WR_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Bit position of the word index inside a byte address.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register array with byte-strobed synchronous write, combinational read
// and asynchronous clear.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS),
  parameter int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];

  // Byte-lane write of the addressed word; whole array cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_r[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[ridx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed words with independent
// write and read FSMs, SLVERR on out-of-range addresses and a write notify.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        awvalid,
  input  logic [ADDRESS_WIDTH-1:0]    awaddr,
  output logic                        awready,
  input  logic                        wvalid,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  output logic                        wready,
  output logic                        bvalid,
  output logic [1:0]                  bresp,
  input  logic                        bready,
  input  logic                        arvalid,
  input  logic [ADDRESS_WIDTH-1:0]    araddr,
  output logic                        arready,
  output logic                        rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  input  logic                        rready,
  output logic                        reg_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] reg_wr_idx
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int LSB    = addr_lsb(DATA_WIDTH);

  wr_state_t             wr_state_r;
  rd_state_t             rd_state_r;
  logic [IDX_W-1:0]      aw_idx_r;
  logic                  aw_oor_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_W-1:0]     w_strb_r;
  logic                  awready_r, wready_r, bvalid_r, pulse_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [IDX_W-1:0]      pulse_idx_r;
  logic                  arready_r, rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  commit_s, commit_oor_s;
  logic [IDX_W-1:0]      commit_idx_s;
  logic [DATA_WIDTH-1:0] commit_data_s, rf_rdata_s;
  logic [STRB_W-1:0]     commit_strb_s;

  // NUM_REGS is a power of two, so any set bit above the index field is out of range.
  function automatic logic out_of_range(input logic [ADDRESS_WIDTH-1:0] addr);
    return (addr >> (LSB + IDX_W)) != {ADDRESS_WIDTH{1'b0}};
  endfunction

  // Select address/data sources for a commit from latched or live channels.
  always_comb begin
    commit_s      = 1'b0;
    commit_idx_s  = awaddr[LSB +: IDX_W];
    commit_oor_s  = out_of_range(awaddr);
    commit_data_s = wdata;
    commit_strb_s = wstrb;
    case (wr_state_r)
      WR_IDLE:   commit_s = awvalid & awready_r & wvalid & wready_r;
      WR_HAVE_A: begin
        commit_s     = wvalid & wready_r;
        commit_idx_s = aw_idx_r;
        commit_oor_s = aw_oor_r;
      end
      WR_HAVE_D: begin
        commit_s      = awvalid & awready_r;
        commit_data_s = w_data_r;
        commit_strb_s = w_strb_r;
      end
      default:   commit_s = 1'b0;
    endcase
  end

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_s & ~commit_oor_s),
    .widx  (commit_idx_s),
    .wdata (commit_data_s),
    .wstrb (commit_strb_s),
    .ridx  (araddr[LSB +: IDX_W]),
    .rdata (rf_rdata_s)
  );

  // Write FSM with registered readies, B response and notify pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_r  <= WR_IDLE;
      aw_idx_r    <= '0;
      aw_oor_r    <= 1'b0;
      w_data_r    <= '0;
      w_strb_r    <= '0;
      awready_r   <= 1'b1;
      wready_r    <= 1'b1;
      bvalid_r    <= 1'b0;
      bresp_r     <= RESP_OKAY;
      pulse_r     <= 1'b0;
      pulse_idx_r <= '0;
    end else begin
      pulse_r <= 1'b0;
      if (commit_s) begin
        wr_state_r <= WR_RESP;
        awready_r  <= 1'b0;
        wready_r   <= 1'b0;
        bvalid_r   <= 1'b1;
        bresp_r    <= commit_oor_s ? RESP_SLVERR : RESP_OKAY;
        pulse_r    <= ~commit_oor_s;
        if (!commit_oor_s) begin
          pulse_idx_r <= commit_idx_s;
        end
      end else begin
        case (wr_state_r)
          WR_IDLE: begin
            if (awvalid) begin
              aw_idx_r   <= awaddr[LSB +: IDX_W];
              aw_oor_r   <= out_of_range(awaddr);
              awready_r  <= 1'b0;
              wr_state_r <= WR_HAVE_A;
            end else if (wvalid) begin
              w_data_r   <= wdata;
              w_strb_r   <= wstrb;
              wready_r   <= 1'b0;
              wr_state_r <= WR_HAVE_D;
            end
          end
          WR_RESP: begin
            if (bready) begin
              bvalid_r   <= 1'b0;
              awready_r  <= 1'b1;
              wready_r   <= 1'b1;
              wr_state_r <= WR_IDLE;
            end
          end
          default: wr_state_r <= wr_state_r;
        endcase
      end
    end
  end

  // Read FSM: sample the word at AR handshake, hold R until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rdata_r    <= '0;
      rresp_r    <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (arvalid) begin
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rdata_r    <= out_of_range(araddr) ? '0 : rf_rdata_s;
            rresp_r    <= out_of_range(araddr) ? RESP_SLVERR : RESP_OKAY;
            rd_state_r <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready) begin
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rd_state_r <= RD_IDLE;
          end
        end
        default: rd_state_r <= RD_IDLE;
      endcase
    end
  end

  assign awready      = awready_r;
  assign wready       = wready_r;
  assign bvalid       = bvalid_r;
  assign bresp        = bresp_r;
  assign arready      = arready_r;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;
  assign rresp        = rresp_r;
  assign reg_wr_pulse = pulse_r;
  assign reg_wr_idx   = pulse_idx_r;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed self-checking bench for axi4_lite_slave_regs: one task per scenario,
// inputs driven and outputs sampled 1ns after the rising edge.
module tb_axi4_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        awready, wready, bvalid, arready, rvalid, reg_wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  reg_wr_idx;

  int checks = 0;
  int errors = 0;

  axi4_lite_slave_regs #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_wr_pulse(reg_wr_pulse), .reg_wr_idx(reg_wr_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW+W on the same cycle; captures B-side outputs the cycle after commit, then accepts B.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic bv, output logic [1:0] br, output logic pl, output logic [3:0] ix);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    bv = bvalid; br = bresp; pl = reg_wr_pulse; ix = reg_wr_idx;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic rv, output logic [31:0] rd, output logic [1:0] rr);
    arvalid = 1'b1; araddr = a;
    step();
    arvalid = 1'b0;
    rv = rvalid; rd = rdata; rr = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL reset_readys: got %b want 111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, reg_wr_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b want 000", {bvalid, rvalid, reg_wr_pulse});
    end
    checks++;
    if ({bresp, rresp, rdata, reg_wr_idx} !== 40'h0) begin
      errors++; $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h idx=%0d want all 0", bresp, rresp, rdata, reg_wr_idx);
    end
  endtask

  task automatic test_write_read();
    logic bv, pl, rv; logic [1:0] br, rr; logic [3:0] ix; logic [31:0] rd;
    do_write(32'h8, 32'hDEADBEEF, 4'hF, bv, br, pl, ix);
    checks++;
    if ({bv, br, pl, ix} !== {1'b1, 2'b00, 1'b1, 4'd2}) begin
      errors++; $display("FAIL wr_basic: bvalid=%b bresp=%b pulse=%b idx=%0d want 1 00 1 2", bv, br, pl, ix);
    end
    do_read(32'h8, rv, rd, rr);
    checks++;
    if ({rv, rd, rr} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
      errors++; $display("FAIL rd_basic: rvalid=%b rdata=%h rresp=%b want 1 deadbeef 00", rv, rd, rr);
    end
  endtask

  task automatic test_w_before_aw();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        errors++; $display("FAIL w_wait[%0d]: wready/awready/bvalid=%b want 010", i, {wready, awready, bvalid});
      end
      if (i < 2) step();
    end
    awvalid = 1'b1; awaddr = 32'h8;
    step();
    awvalid = 1'b0;
    checks++;
    if ({bvalid, bresp, reg_wr_pulse, reg_wr_idx} !== {1'b1, 2'b00, 1'b1, 4'd2}) begin
      errors++; $display("FAIL w_first_resp: bvalid=%b bresp=%b pulse=%b idx=%0d want 1 00 1 2", bvalid, bresp, reg_wr_pulse, reg_wr_idx);
    end
    bready = 1'b1; step(); bready = 1'b0;
    do_read(32'h8, rv, rd, rr);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++; $display("FAIL w_first_strb: rdata=%h want de22be44", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic bv, pl, rv; logic [1:0] br, rr; logic [3:0] ix; logic [31:0] rd;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, bv, br, pl, ix);
    checks++;
    if ({bv, br, pl} !== {1'b1, 2'b10, 1'b0}) begin
      errors++; $display("FAIL oor_write: bvalid=%b bresp=%b pulse=%b want 1 10 0", bv, br, pl);
    end
    do_read(32'h40, rv, rd, rr);
    checks++;
    if ({rv, rd, rr} !== {1'b1, 32'h0, 2'b10}) begin
      errors++; $display("FAIL oor_read: rvalid=%b rdata=%h rresp=%b want 1 0 10", rv, rd, rr);
    end
    do_read(32'h0, rv, rd, rr);
    checks++;
    if ({rd, rr} !== {32'h0, 2'b00}) begin
      errors++; $display("FAIL oor_alias: reg0=%h rresp=%b want 0 00", rd, rr);
    end
  endtask

  task automatic test_backpressure();
    logic rv, bv, pl; logic [1:0] rr, br; logic [3:0] ix; logic [31:0] rd;
    awvalid = 1'b1; awaddr = 32'hC; wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, 2'b00, 2'b00}) begin
        errors++; $display("FAIL b_stall[%0d]: bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0", i, bvalid, bresp, awready, wready);
      end
      step();
    end
    bready = 1'b1; step(); bready = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      errors++; $display("FAIL b_release: awready/wready/bvalid=%b want 110", {awready, wready, bvalid});
    end
    do_write(32'h10, 32'hA5A5A5A5, 4'hF, bv, br, pl, ix);
    checks++;
    if ({bv, pl, ix} !== {1'b1, 1'b1, 4'd4}) begin
      errors++; $display("FAIL b_next_aw: bvalid=%b pulse=%b idx=%0d want 1 1 4", bv, pl, ix);
    end
    arvalid = 1'b1; araddr = 32'hC;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready, rdata, rresp} !== {1'b1, 1'b0, 32'h12345678, 2'b00}) begin
        errors++; $display("FAIL r_stall[%0d]: rvalid=%b arready=%b rdata=%h rresp=%b want 1 0 12345678 00", i, rvalid, arready, rdata, rresp);
      end
      step();
    end
    rready = 1'b1; step(); rready = 1'b0;
    checks++;
    if ({arready, rvalid} !== 2'b10) begin
      errors++; $display("FAIL r_release: arready/rvalid=%b want 10", {arready, rvalid});
    end
    do_read(32'h10, rv, rd, rr);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL b_next_data: rdata=%h want a5a5a5a5", rd);
    end
  endtask

  task automatic test_rd_wr_collision();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    awvalid = 1'b1; awaddr = 32'h4; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h4;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if ({rvalid, rdata, bvalid, reg_wr_pulse} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL collide_old: rvalid=%b rdata=%h bvalid=%b pulse=%b want 1 0 1 1", rvalid, rdata, bvalid, reg_wr_pulse);
    end
    bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
    do_read(32'h4, rv, rd, rr);
    checks++;
    if (rd !== 32'h55) begin
      errors++; $display("FAIL collide_new: rdata=%h want 55", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    awvalid = 1'b1; awaddr = 32'h14;
    step();
    awvalid = 1'b0;
    checks++;
    if ({awready, wready} !== 2'b01) begin
      errors++; $display("FAIL have_a: awready/wready=%b want 01", {awready, wready});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin
      errors++; $display("FAIL mid_reset: bvalid/aw/w/ar=%b want 0111", {bvalid, awready, wready, arready});
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    do_read(32'h8, rv, rd, rr);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_clear: reg2=%h want 0", rd);
    end
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
    step();
    wvalid = 1'b0;
    step();
    checks++;
    if ({bvalid, reg_wr_pulse, wready} !== 3'b000) begin
      errors++; $display("FAIL abandoned_aw: bvalid/pulse/wready=%b want 000", {bvalid, reg_wr_pulse, wready});
    end
    do_read(32'h14, rv, rd, rr);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL no_commit: reg5=%h want 0", rd);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    step();
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_rd_wr_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
